// File: rtl/timer_device.sv
// RISC-V machine timer (mtime/mtimecmp) bus device with programmable prescaler.
// Every request is answered exactly one cycle later; the timer interrupt is a registered level.
module timer_device #(
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned PrescaleWidth = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    dev_req_i,
  input  logic [AddressWidth-1:0] dev_addr_i,
  input  logic                    dev_we_i,
  input  logic [DataWidth/8-1:0]  dev_be_i,
  input  logic [DataWidth-1:0]    dev_wdata_i,
  output logic                    dev_rvalid_o,
  output logic [DataWidth-1:0]    dev_rdata_o,
  output logic                    dev_err_o,
  output logic                    timer_irq_o
);

  localparam logic [2:0] RegMtimeLo = 3'd0;
  localparam logic [2:0] RegMtimeHi = 3'd1;
  localparam logic [2:0] RegCmpLo   = 3'd2;
  localparam logic [2:0] RegCmpHi   = 3'd3;
  localparam logic [2:0] RegPresc   = 3'd4;
  localparam logic [2:0] RegCtrl    = 3'd5;

  logic [63:0]              mtime_q, mtime_d;
  logic [63:0]              mtimecmp_q, mtimecmp_d;
  logic [PrescaleWidth-1:0] prescale_q, prescale_d;
  logic [PrescaleWidth-1:0] presc_cnt_q, presc_cnt_d;
  logic                     ctrl_en_q, ctrl_en_d;
  logic [2:0]               reg_sel;
  logic                     addr_err;
  logic                     wr_hit;
  logic                     tick;
  logic [DataWidth-1:0]     rd_value;
  logic [DataWidth-1:0]     presc_merged;
  logic [DataWidth-1:0]     ctrl_merged;
  logic                     unused_addr;

  // Upper address bits were already decoded by the bus.
  assign unused_addr = ^dev_addr_i[AddressWidth-1:5];

  assign reg_sel  = dev_addr_i[4:2];
  assign addr_err = (dev_addr_i[1:0] != 2'b00) || (reg_sel[2:1] == 2'b11);
  // A write with no byte enables is a pure no-op: it neither suppresses a tick nor clears the prescaler.
  assign wr_hit   = dev_req_i && dev_we_i && !addr_err && (|dev_be_i);
  assign tick     = ctrl_en_q && (presc_cnt_q == prescale_q);

  function automatic logic [DataWidth-1:0] byte_merge(
    input logic [DataWidth-1:0]   old_val,
    input logic [DataWidth-1:0]   new_val,
    input logic [DataWidth/8-1:0] be
  );
    logic [DataWidth-1:0] res;
    res = old_val;
    for (int b = 0; b < DataWidth / 8; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign presc_merged = byte_merge({{(DataWidth-PrescaleWidth){1'b0}}, prescale_q},
                                   dev_wdata_i, dev_be_i);
  assign ctrl_merged  = byte_merge({{(DataWidth-1){1'b0}}, ctrl_en_q}, dev_wdata_i, dev_be_i);

  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    prescale_d  = prescale_q;
    ctrl_en_d   = ctrl_en_q;
    presc_cnt_d = presc_cnt_q;

    // A software write to mtime wins over the tick; unwritten bytes hold.
    if (wr_hit && reg_sel == RegMtimeLo) begin
      mtime_d[31:0] = byte_merge(mtime_q[31:0], dev_wdata_i, dev_be_i);
    end else if (wr_hit && reg_sel == RegMtimeHi) begin
      mtime_d[63:32] = byte_merge(mtime_q[63:32], dev_wdata_i, dev_be_i);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    if (wr_hit && reg_sel == RegCmpLo) begin
      mtimecmp_d[31:0] = byte_merge(mtimecmp_q[31:0], dev_wdata_i, dev_be_i);
    end
    if (wr_hit && reg_sel == RegCmpHi) begin
      mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], dev_wdata_i, dev_be_i);
    end
    if (wr_hit && reg_sel == RegPresc) begin
      prescale_d = presc_merged[PrescaleWidth-1:0];
    end
    if (wr_hit && reg_sel == RegCtrl) begin
      ctrl_en_d = ctrl_merged[0];
    end

    if (wr_hit && (reg_sel == RegPresc || reg_sel == RegCtrl)) begin
      presc_cnt_d = '0;
    end else if (tick) begin
      presc_cnt_d = '0;
    end else if (ctrl_en_q) begin
      presc_cnt_d = presc_cnt_q + {{(PrescaleWidth-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    rd_value = '0;
    case (reg_sel)
      RegMtimeLo: rd_value = mtime_q[31:0];
      RegMtimeHi: rd_value = mtime_q[63:32];
      RegCmpLo:   rd_value = mtimecmp_q[31:0];
      RegCmpHi:   rd_value = mtimecmp_q[63:32];
      RegPresc:   rd_value = {{(DataWidth-PrescaleWidth){1'b0}}, prescale_q};
      RegCtrl:    rd_value = {{(DataWidth-1){1'b0}}, ctrl_en_q};
      default:    rd_value = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtime_q      <= '0;
      mtimecmp_q   <= '1;
      prescale_q   <= '0;
      ctrl_en_q    <= 1'b0;
      presc_cnt_q  <= '0;
      dev_rvalid_o <= 1'b0;
      dev_rdata_o  <= '0;
      dev_err_o    <= 1'b0;
      timer_irq_o  <= 1'b0;
    end else begin
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      prescale_q   <= prescale_d;
      ctrl_en_q    <= ctrl_en_d;
      presc_cnt_q  <= presc_cnt_d;
      dev_rvalid_o <= dev_req_i;
      dev_rdata_o  <= (dev_req_i && !dev_we_i && !addr_err) ? rd_value : '0;
      dev_err_o    <= dev_req_i && addr_err;
      timer_irq_o  <= (mtime_d >= mtimecmp_d);
    end
  end

endmodule

// File: tb/tb_timer_device.sv
// Randomized scoreboard bench for timer_device against a behavioural timer model.
module tb_timer_device;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dev_req_i;
  logic [31:0] dev_addr_i;
  logic        dev_we_i;
  logic [3:0]  dev_be_i;
  logic [31:0] dev_wdata_i;
  logic        dev_rvalid_o;
  logic [31:0] dev_rdata_o;
  logic        dev_err_o;
  logic        timer_irq_o;

  timer_device dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .dev_req_i   (dev_req_i),
    .dev_addr_i  (dev_addr_i),
    .dev_we_i    (dev_we_i),
    .dev_be_i    (dev_be_i),
    .dev_wdata_i (dev_wdata_i),
    .dev_rvalid_o(dev_rvalid_o),
    .dev_rdata_o (dev_rdata_o),
    .dev_err_o   (dev_err_o),
    .timer_irq_o (timer_irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t q[$];
  int    errors = 0;
  int    checks = 0;
  bit    mon_on = 1'b0;

  // Reference state: plain 64-bit time and compare, prescaler as a cycle counter.
  logic [63:0] m_mtime = '0;
  logic [63:0] m_cmp   = '1;
  logic [15:0] m_presc = '0;
  logic        m_en    = 1'b0;
  int unsigned m_cnt   = 0;
  logic        m_irq   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] w,
                                         input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int sel);
    case (sel)
      0: return m_mtime[31:0];
      1: return m_mtime[63:32];
      2: return m_cmp[31:0];
      3: return m_cmp[63:32];
      4: return {16'h0, m_presc};
      5: return {31'h0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk_i) begin
    int          sel;
    bit          err, wr, tick;
    resp_t       r;
    logic [31:0] tmp;
    if (rst_i) begin
      m_mtime = '0; m_cmp = '1; m_presc = '0; m_en = 1'b0; m_cnt = 0; m_irq = 1'b0;
      q.delete();
    end else begin
      sel  = int'(dev_addr_i[4:2]);
      err  = (dev_addr_i[1:0] != 2'b00) || (sel > 5);
      wr   = dev_req_i && dev_we_i && !err && (dev_be_i != 4'h0);
      tick = m_en && (m_cnt == 32'(m_presc));
      if (dev_req_i) begin
        r.err   = err;
        r.rdata = (!dev_we_i && !err) ? m_read(sel) : 32'h0;
        q.push_back(r);
      end
      if (wr && sel == 0)      m_mtime[31:0]  = bmerge(m_mtime[31:0], dev_wdata_i, dev_be_i);
      else if (wr && sel == 1) m_mtime[63:32] = bmerge(m_mtime[63:32], dev_wdata_i, dev_be_i);
      else if (tick)           m_mtime = m_mtime + 64'd1;
      if (wr && (sel == 4 || sel == 5)) m_cnt = 0;
      else if (tick)                    m_cnt = 0;
      else if (m_en)                    m_cnt = m_cnt + 1;
      if (wr && sel == 2) m_cmp[31:0]  = bmerge(m_cmp[31:0], dev_wdata_i, dev_be_i);
      if (wr && sel == 3) m_cmp[63:32] = bmerge(m_cmp[63:32], dev_wdata_i, dev_be_i);
      if (wr && sel == 4) begin
        tmp = bmerge({16'h0, m_presc}, dev_wdata_i, dev_be_i);
        m_presc = tmp[15:0];
      end
      if (wr && sel == 5) begin
        tmp = bmerge({31'h0, m_en}, dev_wdata_i, dev_be_i);
        m_en = tmp[0];
      end
      m_irq = (m_mtime >= m_cmp);
    end
  end

  always @(negedge clk_i) begin
    resp_t r;
    if (mon_on) begin
      if (q.size() > 0) begin
        r = q.pop_front();
        chk("rvalid", 64'(dev_rvalid_o), 64'd1);
        chk("rdata", 64'(dev_rdata_o), 64'(r.rdata));
        chk("err", 64'(dev_err_o), 64'(r.err));
      end else begin
        chk("idle_rvalid", 64'(dev_rvalid_o), 64'd0);
        chk("idle_rdata", 64'(dev_rdata_o), 64'd0);
        chk("idle_err", 64'(dev_err_o), 64'd0);
      end
      chk("irq", 64'(timer_irq_o), 64'(m_irq));
    end
  end

  task automatic bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata);
    dev_req_i = 1'b1; dev_we_i = we; dev_addr_i = addr; dev_be_i = be; dev_wdata_i = wdata;
    @(posedge clk_i); #1;
    dev_req_i = 1'b0; dev_we_i = 1'b0; dev_addr_i = '0; dev_be_i = '0; dev_wdata_i = '0;
  endtask

  task automatic rd(input int idx);
    bus(1'b0, 32'(idx) << 2, 4'h0, 32'h0);
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    bus(1'b1, 32'(idx) << 2, 4'hF, d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic rst_during_req();
    dev_req_i = 1'b1; dev_we_i = 1'b0; dev_addr_i = 32'h0; dev_be_i = 4'h0; rst_i = 1'b1;
    @(posedge clk_i); #1;
    dev_req_i = 1'b0; rst_i = 1'b0;
  endtask

  initial begin
    logic [31:0] a, w;
    int          idx;
    rst_i = 1'b1; dev_req_i = 1'b0; dev_we_i = 1'b0; dev_addr_i = '0;
    dev_be_i = '0; dev_wdata_i = '0;
    @(posedge clk_i); #1;
    mon_on = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) rd(i);

    wr(4, 32'd3); wr(5, 32'd1);
    idle(40);
    rd(0); rd(0); idle(2); rd(0); idle(3); rd(0);

    wr(5, 32'd0); wr(4, 32'd0); wr(0, 32'd0); wr(1, 32'd0);
    wr(3, 32'd0); wr(2, 32'd20); wr(5, 32'd1);
    idle(25); rd(0);
    wr(2, 32'hFFFF_FFFF); idle(3);

    wr(5, 32'd0); wr(1, 32'hFFFF_FFFF); wr(0, 32'hFFFF_FFFE); wr(5, 32'd1);
    idle(1); wr(5, 32'd0); rd(0); rd(1);
    wr(1, 32'd5); wr(0, 32'hFFFF_FFFF); wr(5, 32'd1); wr(5, 32'd0); rd(0); rd(1);

    wr(5, 32'd1); idle(3);
    bus(1'b1, 32'h0, 4'b0101, 32'hAABB_CCDD); rd(0);
    bus(1'b1, 32'h8, 4'b0000, 32'h1234_5678); rd(2);

    bus(1'b0, 32'h18, 4'h0, 32'h0); bus(1'b0, 32'h1C, 4'h0, 32'h0);
    bus(1'b1, 32'h02, 4'hF, 32'hDEAD_BEEF); rd(0); rd(2);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) rd(i % 6); else wr(4, 32'(i));
    end
    rst_during_req();
    idle(2);
    for (int i = 0; i < 6; i++) rd(i);

    for (int i = 0; i < 300; i++) begin
      idx = $urandom_range(0, 7);
      a   = $urandom;
      a   = (a & 32'hFFFF_FFE0) | (32'(idx) << 2);
      if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
      w   = $urandom;
      if (idx == 4) w = w & 32'h7;
      if (idx == 1 && $urandom_range(0, 1) == 1) w = 32'h0;
      bus(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
      if (i == 150) rst_during_req();
    end

    idle(3);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_device.md
# timer_device

Memory-mapped RISC-V machine timer (mtime/mtimecmp) that sits directly downstream of the system bus as one of its devices. It accepts single-cycle requests from the bus device port, always answers exactly one cycle later, and drives a level timer interrupt to the core. A programmable prescaler derives the mtime tick from the system clock.

## Interface
- DataWidth, 32, bus data width; only 32 is supported.
- AddressWidth, 32, bus address width.
- PrescaleWidth, 16, width of the prescaler reload register.
- clk_i  input  1  system clock.
- rst_i  input  1  reset; one clock; reset is synchronous and active-high.
- dev_req_i  input  1  request valid, one cycle per transfer.
- dev_addr_i  input  AddressWidth  byte address; bits [4:2] select the register, upper bits ignored because the bus has already decoded them.
- dev_we_i  input  1  1 = write, 0 = read.
- dev_be_i  input  DataWidth/8  byte enables, writes only.
- dev_wdata_i  input  DataWidth  write data.
- dev_rvalid_o  output  1  response valid, one cycle after dev_req_i.
- dev_rdata_o  output  DataWidth  read data, valid with dev_rvalid_o.
- dev_err_o  output  1  error response, valid with dev_rvalid_o.
- timer_irq_o  output  1  level interrupt, registered.

## Operation
- Register map, word offsets from addr[4:2]:
  - 0x00 MTIME_LO.
  - 0x04 MTIME_HI.
  - 0x08 MTIMECMP_LO.
  - 0x0C MTIMECMP_HI.
  - 0x10 PRESCALE, PrescaleWidth bits, upper bits read 0.
  - 0x14 CTRL, bit0 = enable, other bits read 0.
  - 0x18 and 0x1C are errors.
- Errors:
  - Triggered by an access to 0x18/0x1C or by addr[1:0] != 0.
  - Response: dev_err_o=1, dev_rdata_o=0, no register is modified.
- Writes:
  - Byte-masked by dev_be_i; be=0 is a legal no-op write.
  - Writes respond with rdata=0, err=0.
- Reads:
  - Return the register value as it stood in the request cycle, before any same-cycle tick.
- Prescaler:
  - presc_cnt counts up while CTRL.enable=1.
  - When presc_cnt == PRESCALE: presc_cnt resets to 0 and a tick is generated.
  - PRESCALE=0 gives a tick every cycle.
  - CTRL.enable=0 holds presc_cnt and mtime.
  - Any write to PRESCALE or CTRL clears presc_cnt.
- mtime:
  - 64-bit; increments by 1 on each tick.
  - Wraps from 2^64-1 to 0 with no flag.
  - A write to MTIME_LO or MTIME_HI suppresses the tick in that cycle. The written bytes take the written value; unwritten bytes keep their old value and are not incremented.
- Interrupt:
  - timer_irq_o <= (mtime >= mtimecmp), unsigned 64-bit compare, evaluated on post-update values and registered.
  - The interrupt stays asserted until mtimecmp is raised or mtime wraps.
  - There is no software clear; the interrupt is independent of CTRL.enable.

## Timing
- Response latency: dev_rvalid_o=1 exactly one cycle after each cycle with dev_req_i=1. Back-to-back requests give back-to-back responses with no stalls.
- dev_rvalid_o=0 in every cycle not following a request.
- dev_rdata_o=0 and dev_err_o=0 whenever dev_rvalid_o=0.
- Register writes take effect at the clock edge that ends the request cycle. A read in the immediately following cycle returns the new value.
- Interrupt latency: timer_irq_o reflects the state after an update one cycle after the update edge, i.e. one cycle after the mtime tick or mtimecmp write that causes it.
- Reset values, applied when rst_i=1 at a clock edge:
  - mtime=0, mtimecmp=all ones, PRESCALE=0, CTRL=0, presc_cnt=0.
  - dev_rvalid_o=0, dev_rdata_o=0, dev_err_o=0, timer_irq_o=0.
- Reset mid-transaction: a request accepted in the cycle rst_i is high is discarded and gets no response. A response pending when rst_i rises is dropped.
- After reset, mtime == mtimecmp is not reachable before 2^64-1 ticks, so the interrupt stays low.

## Test plan
- Reset then read all six registers:
  - Returns 0, 0, 0xFFFFFFFF, 0xFFFFFFFF, 0, 0.
  - rvalid arrives exactly one cycle after each request; err=0; irq=0.
- Free-running tick:
  - Stimulus: PRESCALE=3, CTRL=1, then 40 idle cycles.
  - Response: MTIME_LO reads 10 (±1 depending on sampling cycle; the bench checks the exact model value), and increments exactly once every 4 cycles.
- Compare and interrupt:
  - Stimulus: PRESCALE=0, MTIMECMP_HI=0, MTIMECMP_LO=20, then enable.
  - Response: timer_irq_o rises the cycle after mtime reaches 20.
  - Stimulus: write MTIMECMP_LO=0xFFFFFFFF.
  - Response: irq falls one cycle later.
- Carry and wrap:
  - Stimulus: write MTIME_HI=0xFFFFFFFF, MTIME_LO=0xFFFFFFFE, with PRESCALE=0 and enable set.
  - Response: after 2 ticks, MTIME_HI=0 and MTIME_LO=0.
  - Separately: MTIME_LO=0xFFFFFFFF with MTIME_HI=5 rolls over to HI=6.
- Byte enables and collision:
  - Stimulus: with ticking active, write MTIME_LO=0xAABBCCDD with be=4'b0101.
  - Response: only bytes 0 and 2 change, and there is no increment in that cycle.
  - Stimulus: write with be=0.
  - Response: no change.
- Errors and back-to-back:
  - Stimulus: reads at 0x18 and 0x1C, a write to 0x02, and 8 consecutive alternating reads and writes.
  - Response: err=1 with rdata=0 and state unchanged for the errors; one rvalid per request with no gaps.
  - Stimulus: assert rst_i during a pending request.
  - Response: no response and all outputs 0.
